// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to instruction
// memory, buffers returned instructions with their PCs in a small FIFO and
// presents the head entry to decode. A redirect flushes the queue, abandons
// any in-flight fetch and restarts fetching at the target.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        consume,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      drop_addr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             push;
    logic             pop;
    logic [31:0]      redirect_target;

    // Storage holds data only; validity is tracked by count, so no reset here.
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];

    // Low address bits of the redirect target are forced to zero.
    logic             unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};
    assign redirect_target      = {redirect_pc[31:2], 2'b00};

    // A redirect overrides both the push of a returning response and a pop.
    assign push = (state == REQ) && mem_ready && !redirect_valid;
    assign pop  = consume && out_valid && !redirect_valid;

    // Occupancy after this cycle's push/pop (ignores redirect, handled below).
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FIFO control: pointers and occupancy, cleared by redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // FIFO data: capture the returning instruction and the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]   <= fetch_pc;
        end
    end

    // Fetch FSM: IDLE while full, REQ while fetching, DROP while waiting out a stale fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            case (state)
                REQ: begin
                    if (mem_ready) begin
                        state <= REQ;
                    end else begin
                        // Memory still owes a response for the old address; keep asking for it.
                        state     <= DROP;
                        drop_addr <= fetch_pc;
                    end
                end
                DROP: begin
                    // A stale response completing now leaves nothing outstanding.
                    if (mem_ready) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (count_next < FULL_CNT) state <= REQ;
                end
                REQ: begin
                    if (mem_ready) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= (count_next < FULL_CNT) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (mem_ready) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req  = (state == REQ) || (state == DROP);
    assign mem_addr = (state == DROP) ? drop_addr : fetch_pc;

    assign out_valid   = (count != '0);
    assign out_inst    = out_valid ? inst_q[rd_ptr] : 32'd0;
    assign out_pc      = out_valid ? pc_q[rd_ptr] : 32'd0;
    assign out_next_pc = out_pc + 32'd4;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue. A memory responder with random
// latency feeds the DUT; a reference model tracks the expected instruction
// stream (restart at each redirect target, +4 per accepted word, stale
// responses discarded) and pushes expected entries to a scoreboard that a
// separate monitor pops whenever decode consumes a valid head entry.
module tb_inst_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        consume = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .consume        (consume),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_next_pc    (out_next_pc)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          lat_max = 0;
    int          p_cons = 0;
    int          p_redir = 0;
    bit          mon_en = 1'b0;
    bit          popped_full = 1'b0;
    ent_t        sb[$];
    logic [31:0] exp_fetch = RESET_PC;
    bit          stale = 1'b0;
    bit          busy = 1'b0;
    int          wait_left = 0;
    bit          exp_hold = 1'b0;
    bit          exp_req = 1'b0;
    logic [31:0] hold_addr = 32'd0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Stimulus side: drive inputs, check handshake expectations, advance the model.
    task automatic drive_inputs();
        redirect_valid = ($urandom_range(0, 99) < p_redir);
        redirect_pc    = pick_target();
        consume        = ($urandom_range(0, 99) < p_cons);
        if (mem_req) begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = int'($urandom_range(0, lat_max));
            end
            mem_ready = (wait_left == 0);
            mem_rdata = inst_of(mem_addr);
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
    endtask

    task automatic pre_checks();
        if (exp_hold) begin
            chk("hold_req", {31'd0, mem_req}, 32'd1);
            chk("hold_addr", mem_addr, hold_addr);
        end
        if (exp_req) begin
            chk("issue_req", {31'd0, mem_req}, 32'd1);
            chk("issue_addr", mem_addr, exp_fetch);
        end
    endtask

    task automatic model_update();
        bit hs;
        hs        = mem_req && mem_ready;
        exp_hold  = mem_req && !mem_ready;
        hold_addr = mem_addr;
        exp_req   = 1'b0;
        if (redirect_valid) begin
            sb.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
            if (exp_hold) begin
                stale = 1'b1;
            end else begin
                stale   = 1'b0;
                exp_req = 1'b1;
            end
        end else begin
            if (hs) begin
                if (stale) begin
                    stale   = 1'b0;
                    exp_req = 1'b1;
                end else begin
                    chk("fetch_addr", mem_addr, exp_fetch);
                    sb.push_back('{pc: exp_fetch, inst: inst_of(exp_fetch)});
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
            if (popped_full) exp_req = 1'b1;
        end
        if (hs) busy = 1'b0;
        else if (mem_req) wait_left--;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_inputs();
        pre_checks();
        #2;
        model_update();
    endtask

    task automatic run(input int n, input int lat, input int pc_, input int pr);
        lat_max = lat;
        p_cons  = pc_;
        p_redir = pr;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic model_reset();
        sb.delete();
        exp_fetch   = RESET_PC;
        stale       = 1'b0;
        busy        = 1'b0;
        wait_left   = 0;
        exp_hold    = 1'b0;
        exp_req     = 1'b0;
        popped_full = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, RESET_PC);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_inst"}, out_inst, 32'd0);
        chk({tag, "_out_pc"}, out_pc, 32'd0);
        chk({tag, "_out_next_pc"}, out_next_pc, 32'd4);
    endtask

    // Monitor: compares the presented head entry against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                popped_full = 1'b0;
                chk("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
                if (sb.size() == 0) begin
                    chk("empty_pc", out_pc, 32'd0);
                    chk("empty_inst", out_inst, 32'd0);
                    chk("empty_next_pc", out_next_pc, 32'd4);
                end
                if (sb.size() == DEPTH) chk("full_no_req", {31'd0, mem_req}, 32'd0);
                if (consume && !redirect_valid && sb.size() != 0) begin
                    ent_t e;
                    if (sb.size() == DEPTH) popped_full = 1'b1;
                    e = sb.pop_front();
                    chk("head_pc", out_pc, e.pc);
                    chk("head_inst", out_inst, e.inst);
                    chk("head_next_pc", out_next_pc, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        bit found;
        // Reset state.
        #1 reset = 1'b1;
        #1 check_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        exp_req = 1'b1;
        mon_en  = 1'b1;

        // Zero-latency memory, decode stalled: queue fills with 0,4,8,C then stops.
        run(12, 0, 0, 0);
        chk("fill_mem_req", {31'd0, mem_req}, 32'd0);
        chk("fill_head_pc", out_pc, 32'd0);
        chk("fill_head_inst", out_inst, inst_of(32'd0));

        // Drain and refill continuously, then random mixes of latency/stall/redirect.
        run(20, 0, 100, 0);
        run(1500, 3, 60, 8);
        run(600, 0, 100, 20);

        // Asynchronous reset while a request is waiting on memory.
        lat_max = 3;
        p_cons  = 30;
        p_redir = 0;
        found   = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            drive_inputs();
            pre_checks();
            if (mem_req && !mem_ready) found = 1'b1;
            else begin
                #2;
                model_update();
            end
        end
        chk("req_wait_found", {31'd0, found}, 32'd1);
        #3 reset = 1'b1;
        mon_en = 1'b0;
        #1 check_reset_outputs("rst_mid");
        redirect_valid = 1'b0;
        consume        = 1'b0;
        mem_ready      = 1'b0;
        model_reset();
        @(negedge clk);
        reset   = 1'b0;
        exp_req = 1'b1;
        mon_en  = 1'b1;

        run(1000, 2, 50, 12);

        @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
